// File: rtl/ifu_cache_ctrl_if.sv
// Core-fetch and memory-fill signal bundle for ifu_cache_ctrl.
// The slave modport is the cache controller; master is the core/memory side.
interface ifu_cache_ctrl_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LINE_BITS = 128
);
  logic              core_req_valid;
  logic              core_req_ready;
  logic [ADDR_W-1:0] core_req_addr;
  logic              core_rsp_valid;
  logic [DATA_W-1:0] core_rsp_data;
  logic              flush;

  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [ADDR_W-1:0]    mem_req_addr;
  logic                 mem_rsp_valid;
  logic [LINE_BITS-1:0] mem_rsp_data;

  modport slave (
    input  core_req_valid, core_req_addr, flush,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output core_req_ready, core_rsp_valid, core_rsp_data,
           mem_req_valid, mem_req_addr
  );

  modport master (
    output core_req_valid, core_req_addr, flush,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  core_req_ready, core_rsp_valid, core_rsp_data,
           mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/ifu_cache_ctrl.sv
// Fully-associative IFU instruction-cache controller driving the plru replacement tree.
// Define IFU_CACHE_PERF_EN to add saturating hit_cnt/miss_cnt outputs.
package ifu_pkg;
  localparam int WAYS_NUM = 16;
  localparam int WAY_W    = $clog2(WAYS_NUM);

  typedef struct packed {
    logic             update_tree;
    logic             cache_miss;
    logic [WAY_W-1:0] hit_cl;
  } t_cache_ctrl_plru;
endpackage

module ifu_cache_ctrl #(
  parameter int WAYS_NUM   = ifu_pkg::WAYS_NUM,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  ifu_cache_ctrl_if.slave               bus,
  output ifu_pkg::t_cache_ctrl_plru     cache_ctrl_plru,
  input  logic [$clog2(WAYS_NUM)-1:0]   evicted_cl
`ifdef IFU_CACHE_PERF_EN
  ,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt
`endif
);

  localparam int OFFSET_W  = $clog2(LINE_BYTES);
  localparam int LINE_BITS = 8 * LINE_BYTES;
  localparam int TAG_W     = ADDR_W - OFFSET_W;
  localparam int WORD_W    = OFFSET_W - 2;
  localparam int WAY_W     = $clog2(WAYS_NUM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_WAIT_FILL,
    S_RESP
  } state_t;

  state_t               state;
  logic [ADDR_W-1:0]    req_addr_q;
  logic                 flush_pend;
  logic                 hit_q;
  logic [WAY_W-1:0]     hit_way_q;
  logic [WAYS_NUM-1:0]  valid_q;
  logic [TAG_W-1:0]     tag_q  [WAYS_NUM];
  logic [LINE_BITS-1:0] data_q [WAYS_NUM];

  logic                 rsp_valid_q;
  logic [DATA_W-1:0]    rsp_data_q;
  logic                 mem_req_valid_q;
  logic [ADDR_W-1:0]    mem_req_addr_q;

  logic [TAG_W-1:0]     in_tag;
  logic [WORD_W-1:0]    in_word;
  logic [WORD_W-1:0]    req_word;
  logic [WAYS_NUM-1:0]  match;
  logic                 hit_in;
  logic [WAY_W-1:0]     hit_way_in;
  logic                 fill;

  function automatic logic [DATA_W-1:0] line_word(input logic [LINE_BITS-1:0] line,
                                                  input logic [WORD_W-1:0]    idx);
    return line[int'(idx)*DATA_W +: DATA_W];
  endfunction

  assign in_tag   = bus.core_req_addr[ADDR_W-1:OFFSET_W];
  assign in_word  = bus.core_req_addr[OFFSET_W-1:2];
  assign req_word = req_addr_q[OFFSET_W-1:2];
  assign fill     = (state == S_WAIT_FILL) && bus.mem_rsp_valid && !rst;

  // Lookup runs on the incoming address so the hit response can be registered
  // into S_LOOKUP; the arrays cannot change between accept and lookup.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    match      = '0;
    hit_way_in = '0;
    for (int w = 0; w < WAYS_NUM; w++) begin
      match[w] = valid_q[w] && (tag_q[w] == in_tag);
      if (match[w]) hit_way_in = WAY_W'(w);
    end
  end
  assign hit_in = |match;

  // plru control is combinational: evicted_cl answers cache_miss in the same cycle.
  always_comb begin
    cache_ctrl_plru = '0;
    if (!rst && state == S_LOOKUP && hit_q) begin
      cache_ctrl_plru.update_tree = 1'b1;
      cache_ctrl_plru.hit_cl      = hit_way_q;
    end else if (fill) begin
      cache_ctrl_plru.update_tree = 1'b1;
      cache_ctrl_plru.cache_miss  = 1'b1;
    end
  end

  assign bus.core_req_ready = (state == S_IDLE) && !bus.flush && !flush_pend;
  assign bus.core_rsp_valid = rsp_valid_q;
  assign bus.core_rsp_data  = rsp_data_q;
  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_req_addr   = mem_req_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      req_addr_q      <= '0;
      flush_pend      <= 1'b0;
      hit_q           <= 1'b0;
      hit_way_q       <= '0;
      valid_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      rsp_valid_q <= 1'b0;
      if (bus.flush && state != S_IDLE) flush_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.flush || flush_pend) begin
            valid_q    <= '0;
            flush_pend <= 1'b0;
          end else if (bus.core_req_valid) begin
            req_addr_q  <= bus.core_req_addr;
            hit_q       <= hit_in;
            hit_way_q   <= hit_way_in;
            rsp_valid_q <= hit_in;
            if (hit_in) rsp_data_q <= line_word(data_q[hit_way_in], in_word);
            state       <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_q) begin
            state <= S_IDLE;
          end else begin
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= {req_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            state           <= S_MISS_REQ;
          end
        end
        S_MISS_REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= S_WAIT_FILL;
          end
        end
        S_WAIT_FILL: begin
          if (bus.mem_rsp_valid) begin
            valid_q[evicted_cl] <= 1'b1;
            rsp_valid_q         <= 1'b1;
            rsp_data_q          <= line_word(bus.mem_rsp_data, req_word);
            state               <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: tag/data arrays are not reset; valid_q alone qualifies them, so they map onto plain storage.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[evicted_cl]  <= req_addr_q[ADDR_W-1:OFFSET_W];
      data_q[evicted_cl] <= bus.mem_rsp_data;
    end
  end

`ifdef IFU_CACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit_q) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      end else if (miss_cnt != '1) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

  // Byte-within-word address bits carry no information for word fetches.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.core_req_addr[1:0], req_addr_q[1:0]};

  a_rsp_only_in_wait_fill: assert property (@(posedge clk) disable iff (rst)
    bus.mem_rsp_valid |-> state == S_WAIT_FILL);
  a_hit_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(match));

endmodule
